// File: rtl/drfm_pkg.sv
// drfm_pkg: shared state encoding and default sizes for the capture/replay store.
// Default build is single-pass replay; define DRFM_REPLAY_LOOP_EN for looped replay.
package drfm_pkg;

    localparam int DRFM_DEPTH_LOG2 = 10;
    localparam int DRFM_DATA_W     = 32;
    localparam int DRFM_DELAY_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_DELAY,
        ST_PLAY
    } drfm_state_t;

endpackage

// File: rtl/drfm_sample_ram.sv
// drfm_sample_ram: simple dual-port sample store, one write port and one
// registered read port (1-cycle latency), contents never reset.
module drfm_sample_ram
    import drfm_pkg::*;
#(
    parameter int ADDR_W = DRFM_DEPTH_LOG2,
    parameter int DATA_W = DRFM_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write and synchronous read in one clocked block so it maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/drfm_capture_replay.sv
// drfm_capture_replay: records strobed summed samples into RAM and replays them
// after a programmable delay. Macro DRFM_REPLAY_LOOP_EN enables looped replay.
module drfm_capture_replay
    import drfm_pkg::*;
#(
    parameter int DEPTH_LOG2 = DRFM_DEPTH_LOG2,
    parameter int DATA_W     = DRFM_DATA_W,
    parameter int DELAY_W    = DRFM_DELAY_W
) (
    input  logic                M100CLK,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                rec_start,
    input  logic [DEPTH_LOG2:0] rec_len,
    input  logic                play_start,
    input  logic [DELAY_W-1:0]  play_delay,
    input  logic                play_stop,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy,
    output logic                rec_done,
    output logic                play_done
);

    localparam int LEN_W = DEPTH_LOG2 + 1;
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

    drfm_state_t state, state_nxt;

    logic [LEN_W-1:0]   wr_ptr;
    logic [LEN_W-1:0]   rd_ptr;
    logic [LEN_W-1:0]   rec_len_q;
    logic [LEN_W-1:0]   stored_len;
    logic [DELAY_W-1:0] dly_cnt;
    logic [DATA_W-1:0]  rd_data;

    logic rec_go, play_go;
    logic wr_en, rd_en, rd_wrap;
    logic rec_fin, play_fin, abort;
    logic dly_dec;

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        rec_go    = 1'b0;
        play_go   = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_wrap   = 1'b0;
        rec_fin   = 1'b0;
        play_fin  = 1'b0;
        abort     = 1'b0;
        dly_dec   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rec_start && rec_len != '0) begin
                    rec_go    = 1'b1;
                    state_nxt = ST_RECORD;
                end else if (play_start && stored_len != '0) begin
                    play_go   = 1'b1;
                    state_nxt = ST_DELAY;
                end
            end
            ST_RECORD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == rec_len_q - ONE) begin
                        rec_fin   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DELAY: begin
                if (play_stop) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (dly_cnt == '0) begin
                    state_nxt = ST_PLAY;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            ST_PLAY: begin
                if (play_stop) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    rd_en = 1'b1;
                    if (rd_ptr == stored_len - ONE) begin
`ifdef DRFM_REPLAY_LOOP_EN
                        rd_wrap = 1'b1;
`else
                        play_fin  = 1'b1;
                        state_nxt = ST_IDLE;
`endif
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge M100CLK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers, lengths, delay counter and registered strobes
    always_ff @(posedge M100CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rec_len_q  <= '0;
            stored_len <= '0;
            dly_cnt    <= '0;
            out_valid  <= 1'b0;
            rec_done   <= 1'b0;
            play_done  <= 1'b0;
        end else begin
            out_valid <= rd_en;
            rec_done  <= rec_fin;
            play_done <= play_fin | abort;
            if (rec_go) begin
                wr_ptr    <= '0;
                rec_len_q <= (rec_len > MAX_LEN) ? MAX_LEN : rec_len;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rec_fin) begin
                stored_len <= rec_len_q;
            end
            if (play_go) begin
                rd_ptr  <= '0;
                dly_cnt <= play_delay;
            end else begin
                if (dly_dec) begin
                    dly_cnt <= dly_cnt - DELAY_W'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_wrap ? '0 : rd_ptr + ONE;
                end
            end
        end
    end

    drfm_sample_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (M100CLK),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rd_data)
    );

    assign busy     = (state != ST_IDLE);
    assign out_data = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_drfm_capture_replay.sv
// tb_drfm_capture_replay: directed record/replay scenarios with a queue-based
// scoreboard; expected samples, done pulses and their edge numbers are queued.
module tb_drfm_capture_replay;

    localparam int D  = 3;
    localparam int DW = 32;
    localparam int LW = 16;

    typedef struct {
        int          edge_no;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          rec_start;
    logic [D:0]    rec_len;
    logic          play_start;
    logic [LW-1:0] play_delay;
    logic          play_stop;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          rec_done;
    logic          play_done;

    drfm_capture_replay #(
        .DEPTH_LOG2 (D),
        .DATA_W     (DW),
        .DELAY_W    (LW)
    ) dut (
        .M100CLK    (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .rec_start  (rec_start),
        .rec_len    (rec_len),
        .play_start (play_start),
        .play_delay (play_delay),
        .play_stop  (play_stop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .rec_done   (rec_done),
        .play_done  (play_done)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int n_vec = 0;
    int n_bad = 0;

    exp_t q_out[$];
    int   q_rec[$];
    int   q_done[$];

    logic [31:0] vals[8];
    logic [31:0] stored[8];
    int          stored_n = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: sample 1ns after each edge, pop and compare on DUT events
    initial begin
        exp_t e;
        int   x;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (q_out.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    e = q_out.pop_front();
                    chk("out_edge", edge_n, e.edge_no);
                    chk("out_data", out_data, e.data);
                end
            end else begin
                chk("out_zero", out_data, 0);
            end
            if (rec_done) begin
                if (q_rec.size() == 0) begin
                    chk("rec_done_unexpected", 1, 0);
                end else begin
                    x = q_rec.pop_front();
                    chk("rec_done_edge", edge_n, x);
                end
            end
            if (play_done) begin
                if (q_done.size() == 0) begin
                    chk("play_done_unexpected", 1, 0);
                end else begin
                    x = q_done.pop_front();
                    chk("play_done_edge", edge_n, x);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Record n samples (hand-clamped count), optional gap and play_start clash
    task automatic do_record(input int len_req, input int n, input int gap,
                             input bit with_play);
        rec_start  = 1'b1;
        rec_len    = (D+1)'(len_req);
        play_start = with_play;
        play_delay = '0;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        tick();
        rec_start  = 1'b0;
        play_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        chk("busy_after_rec_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            if (i == n - 1) q_rec.push_back(edge_n + 1);
            tick();
            in_valid = 1'b0;
            in_data  = '0;
            for (int g = 0; g < gap; g++) tick();
        end
        tick();
        tick();
        chk("busy_after_record", busy, 0);
        for (int i = 0; i < n; i++) stored[i] = vals[i];
        stored_n = n;
    endtask

    // Replay; stop_k<0 means run to natural end, else stop after stop_k samples
    task automatic do_play(input int dly, input int stop_k, input bit poke);
        int   n0;
        int   cnt;
        int   s;
        int   last;
        exp_t e;
        int   k;
        k = stop_k;
`ifdef DRFM_REPLAY_LOOP_EN
        if (k < 0) k = stored_n;
`endif
        play_start = 1'b1;
        play_delay = LW'(dly);
        n0 = edge_n + 1;
        cnt = (k < 0) ? stored_n : k;
        for (int i = 0; i < cnt; i++) begin
            e.edge_no = n0 + 2 + dly + i;
            e.data    = stored[i % stored_n];
            q_out.push_back(e);
        end
        s = n0 + 2 + dly + k;
        if (k < 0) q_done.push_back(n0 + 1 + dly + stored_n);
        else       q_done.push_back(s);
        tick();
        play_start = 1'b0;
        chk("busy_after_play_start", busy, 1);
        last = n0 + dly + cnt + 6;
        while (edge_n < last) begin
            play_stop = (k >= 0 && edge_n == s - 1);
            if (poke && edge_n == n0 + 1) begin
                rec_start = 1'b1;
                rec_len   = 4'd2;
                in_valid  = 1'b1;
                in_data   = 32'h1234_5678;
            end else begin
                rec_start = 1'b0;
                in_valid  = 1'b0;
                in_data   = '0;
            end
            tick();
        end
        play_stop = 1'b0;
        rec_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        chk("busy_after_play", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        rec_start  = 1'b0;
        rec_len    = '0;
        play_start = 1'b0;
        play_delay = '0;
        play_stop  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_rec_done",  rec_done,  0);
        chk("rst_play_done", play_done, 0);

        // play_start with nothing stored and rec_len=0 both ignored
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        chk("play_ignored_empty", busy, 0);
        rec_start = 1'b1;
        rec_len   = '0;
        tick();
        rec_start = 1'b0;
        chk("rec_len0_ignored", busy, 0);
        tick();

        vals[0] = 32'd10;
        vals[1] = 32'hFFFF_FFFD;
        vals[2] = 32'h7FFF_FFFF;
        vals[3] = 32'h8000_0000;
        do_record(4, 4, 1, 1'b0);

        do_play(0, -1, 1'b0);
        do_play(7, -1, 1'b1);

        for (int i = 0; i < 8; i++) vals[i] = 32'h100 + 32'(i * 17);
        do_record(15, 8, 0, 1'b0);
        do_play(0, 2, 1'b0);

        vals[0] = 32'hAAAA_0001;
        vals[1] = 32'hBBBB_0002;
        vals[2] = 32'hCCCC_0003;
        do_record(3, 3, 1, 1'b1);
`ifdef DRFM_REPLAY_LOOP_EN
        do_play(0, 8, 1'b0);
`endif
        do_play(2, -1, 1'b0);

        // Reset in the middle of a capture
        vals[0] = 32'h5555_0000;
        vals[1] = 32'h6666_0000;
        rec_start = 1'b1;
        rec_len   = 4'd4;
        tick();
        rec_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("midrst_busy",      busy,      0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_rec_done",  rec_done,  0);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        chk("play_after_rst_ignored", busy, 0);
        for (int i = 0; i < 8; i++) tick();

        chk("q_out_left",  q_out.size(),  0);
        chk("q_rec_left",  q_rec.size(),  0);
        chk("q_done_left", q_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
